// File: rtl/sata_phy_ctrl_pkg.sv
// Shared types for the SATA PHY bring-up controller: FSM states and SStatus.DET codes.
package sata_phy_ctrl_pkg;

  typedef enum logic [2:0] {
    S_DISABLED,
    S_WAIT_PLL,
    S_START,
    S_WAIT_LINK,
    S_BACKOFF,
    S_READY,
    S_FAIL
  } state_e;

  localparam logic [3:0] DET_NONE    = 4'h0;
  localparam logic [3:0] DET_PRESENT = 4'h1;
  localparam logic [3:0] DET_PHY     = 4'h3;
  localparam logic [3:0] DET_OFFLINE = 4'h4;

endpackage

// File: rtl/sata_phy_ctrl.sv
// PHY bring-up sequencer: pulses StartComm to the OOB engine, times out link-up with bounded
// retry/backoff, and reports link loss, hot-plug COMINIT and SStatus.DET.
module sata_phy_ctrl
  import sata_phy_ctrl_pkg::*;
#(
  parameter int unsigned C_START_LEN    = 16,
  parameter logic [23:0] C_LINK_TIMEOUT = 24'd1_500_000,
  parameter logic [23:0] C_BACKOFF      = 24'd150_000,
  parameter logic [3:0]  C_MAX_RETRY    = 4'd8
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       port_enable,
  input  logic       port_reset_req,
  input  logic       plllkdet,
  input  logic       tx_sync_done,
  input  logic       link_up,
  input  logic       comm_init,
  output logic       start_comm,
  output logic       phy_rdy,
  output logic [3:0] sstatus_det,
  output logic [3:0] retry_cnt,
  output logic       link_fail,
  output logic       link_lost,
  output logic       cominit_irq
);

  localparam logic [23:0] StartLast   = 24'(C_START_LEN - 1);
  localparam logic [23:0] TimeoutLast = C_LINK_TIMEOUT - 24'd1;
  localparam logic [23:0] BackoffLast = C_BACKOFF - 24'd1;

  state_e      state_q, state_d;
  logic [23:0] timer_q, timer_d;
  logic [3:0]  retry_d;
  logic        dev_seen_q, dev_seen_d;
  logic        comm_init_q;
  logic        restart, cominit_rise;
  logic        start_comm_d, phy_rdy_d, link_fail_d, link_lost_d, cominit_irq_d;
  logic [3:0]  sstatus_det_d;

  assign restart      = port_enable & port_reset_req;
  assign cominit_rise = comm_init & ~comm_init_q;

  // comm_init_q resets high so a COMINIT already asserted out of reset is not an edge.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      state_q     <= S_DISABLED;
      timer_q     <= '0;
      dev_seen_q  <= 1'b0;
      comm_init_q <= 1'b1;
      start_comm  <= 1'b0;
      phy_rdy     <= 1'b0;
      sstatus_det <= DET_OFFLINE;
      retry_cnt   <= '0;
      link_fail   <= 1'b0;
      link_lost   <= 1'b0;
      cominit_irq <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      dev_seen_q  <= dev_seen_d;
      comm_init_q <= comm_init;
      start_comm  <= start_comm_d;
      phy_rdy     <= phy_rdy_d;
      sstatus_det <= sstatus_det_d;
      retry_cnt   <= retry_d;
      link_fail   <= link_fail_d;
      link_lost   <= link_lost_d;
      cominit_irq <= cominit_irq_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (!port_enable) begin
      state_d = S_DISABLED;
    end else if (port_reset_req) begin
      state_d = S_START;
    end else begin
      unique case (state_q)
        S_DISABLED:  state_d = S_WAIT_PLL;
        S_WAIT_PLL:  if (plllkdet && tx_sync_done) state_d = S_START;
        S_START:     if (timer_q == StartLast) state_d = S_WAIT_LINK;
        S_WAIT_LINK: begin
          if (link_up) begin
            state_d = S_READY;
          end else if (timer_q == TimeoutLast) begin
            state_d = (retry_cnt == C_MAX_RETRY) ? S_FAIL : S_BACKOFF;
          end
        end
        S_BACKOFF:   if (timer_q == BackoffLast) state_d = S_START;
        S_READY:     if (!link_up) state_d = S_BACKOFF;
        S_FAIL:      if (cominit_rise) state_d = S_START;
        default:     state_d = S_DISABLED;
      endcase
    end
  end

  always_comb begin
    // A reset request inside S_START keeps the state but must restart the pulse count.
    if ((state_d != state_q) || restart) begin
      timer_d = '0;
    end else begin
      timer_d = (&timer_q) ? timer_q : timer_q + 24'd1;
    end

    retry_d = retry_cnt;
    if ((state_d == S_DISABLED) || (state_d == S_READY) || restart) begin
      retry_d = '0;
    end else if ((state_d == S_START) && (state_q != S_START)) begin
      if (state_q == S_BACKOFF) begin
        retry_d = (&retry_cnt) ? retry_cnt : retry_cnt + 4'd1;
      end else begin
        retry_d = '0;
      end
    end

    dev_seen_d = dev_seen_q;
    if (comm_init) begin
      dev_seen_d = 1'b1;
    end else if ((state_d == S_DISABLED) || restart) begin
      dev_seen_d = 1'b0;
    end

    start_comm_d  = (state_d == S_START);
    phy_rdy_d     = (state_d == S_READY);
    link_fail_d   = (state_d == S_FAIL);
    link_lost_d   = (state_q == S_READY) && (state_d == S_BACKOFF);
    cominit_irq_d = cominit_rise && ((state_q == S_READY) || (state_q == S_FAIL));

    if (state_d == S_DISABLED) begin
      sstatus_det_d = DET_OFFLINE;
    end else if (state_d == S_READY) begin
      sstatus_det_d = DET_PHY;
    end else begin
      sstatus_det_d = dev_seen_d ? DET_PRESENT : DET_NONE;
    end
  end

endmodule

// File: tb/tb_sata_phy_ctrl.sv
// Self-checking bench for sata_phy_ctrl: vector table, directed corner sequences and a
// randomized run checked cycle by cycle against a countdown-based reference model.
module tb_sata_phy_ctrl;

  localparam int LEN  = 4;
  localparam int TO   = 100;
  localparam int BO   = 20;
  localparam int MAXR = 3;

  localparam int M_OFF = 0, M_PLL = 1, M_START = 2, M_WAIT = 3, M_BACK = 4, M_READY = 5;
  localparam int M_FAIL = 6;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic en = 1'b0, rr = 1'b0, pll = 1'b0, txs = 1'b0, lu = 1'b0, ci = 1'b0;
  logic start_comm, phy_rdy, link_fail, link_lost, cominit_irq;
  logic [3:0] sstatus_det, retry_cnt;
  logic [12:0] outs;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model
  int m_mode, m_left, m_retry;
  bit m_seen, m_ci_prev, m_lost, m_irq;

  sata_phy_ctrl #(
    .C_START_LEN   (LEN),
    .C_LINK_TIMEOUT(24'd100),
    .C_BACKOFF     (24'd20),
    .C_MAX_RETRY   (4'd3)
  ) dut (
    .sys_clk       (clk),
    .sys_rst_n     (rst_n),
    .port_enable   (en),
    .port_reset_req(rr),
    .plllkdet      (pll),
    .tx_sync_done  (txs),
    .link_up       (lu),
    .comm_init     (ci),
    .start_comm    (start_comm),
    .phy_rdy       (phy_rdy),
    .sstatus_det   (sstatus_det),
    .retry_cnt     (retry_cnt),
    .link_fail     (link_fail),
    .link_lost     (link_lost),
    .cominit_irq   (cominit_irq)
  );

  always #5 clk = ~clk;

  assign outs = {start_comm, phy_rdy, sstatus_det, retry_cnt, link_fail, link_lost, cominit_irq};

  function automatic logic [12:0] o(bit s, bit r, logic [3:0] d, logic [3:0] rt, bit f, bit l,
                                    bit i);
    return {s, r, d, rt, f, l, i};
  endfunction

  localparam logic [12:0] RST_OUTS = 13'b0_0_0100_0000_0_0_0;

  task automatic check(string name, logic [31:0] got, logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, got, want, $time);
    end
  endtask

  function automatic logic [12:0] model_outs();
    logic [3:0] det;
    if (m_mode == M_OFF) det = 4'h4;
    else if (m_mode == M_READY) det = 4'h3;
    else det = m_seen ? 4'h1 : 4'h0;
    return o(m_mode == M_START, m_mode == M_READY, det, 4'(m_retry), m_mode == M_FAIL, m_lost,
             m_irq);
  endfunction

  task automatic model_reset();
    m_mode = M_OFF; m_left = 0; m_retry = 0;
    m_seen = 0; m_ci_prev = 1; m_lost = 0; m_irq = 0;
  endtask

  task automatic model_step();
    bit rise;
    rise = ci && !m_ci_prev;
    m_irq = rise && (m_mode == M_READY || m_mode == M_FAIL);
    m_ci_prev = ci;
    m_lost = 0;
    if (!en) begin
      m_mode = M_OFF;
    end else if (rr) begin
      m_mode = M_START; m_left = LEN; m_retry = 0;
    end else begin
      case (m_mode)
        M_OFF: m_mode = M_PLL;
        M_PLL: if (pll && txs) begin m_mode = M_START; m_left = LEN; m_retry = 0; end
        M_START: begin
          m_left--;
          if (m_left == 0) begin m_mode = M_WAIT; m_left = TO; end
        end
        M_WAIT: begin
          if (lu) begin
            m_mode = M_READY; m_retry = 0;
          end else begin
            m_left--;
            if (m_left == 0) begin
              if (m_retry == MAXR) m_mode = M_FAIL;
              else begin m_mode = M_BACK; m_left = BO; end
            end
          end
        end
        M_BACK: begin
          m_left--;
          if (m_left == 0) begin
            m_mode = M_START; m_left = LEN;
            m_retry = (m_retry < 15) ? m_retry + 1 : 15;
          end
        end
        M_READY: if (!lu) begin m_mode = M_BACK; m_left = BO; m_lost = 1; end
        M_FAIL: if (rise) begin m_mode = M_START; m_left = LEN; m_retry = 0; end
        default: ;
      endcase
    end
    if (m_mode == M_OFF) m_retry = 0;
    if (ci) m_seen = 1;
    else if (m_mode == M_OFF || (en && rr)) m_seen = 0;
  endtask

  // One clock: model advances with the DUT, outputs compared on the falling edge.
  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    check("model", 32'(outs), 32'(model_outs()));
  endtask

  task automatic do_reset();
    #1;
    rst_n = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    check("reset_vals", 32'(outs), 32'(RST_OUTS));
    rst_n = 1'b1;
  endtask

  typedef struct {
    logic en, rr, pll, txs, lu, ci;
    int n;
    logic [12:0] exp;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int rises[$];
    int high_cycles, irqs, cyc;
    bit prev_s;

    vecs[0]  = '{1, 0, 0, 0, 0, 0, 10, o(0, 0, 0, 0, 0, 0, 0)};
    vecs[1]  = '{1, 0, 1, 1, 0, 0, 1,  o(1, 0, 0, 0, 0, 0, 0)};
    vecs[2]  = '{1, 0, 1, 1, 0, 0, 3,  o(1, 0, 0, 0, 0, 0, 0)};
    vecs[3]  = '{1, 0, 1, 1, 0, 0, 1,  o(0, 0, 0, 0, 0, 0, 0)};
    vecs[4]  = '{1, 0, 1, 1, 0, 0, 29, o(0, 0, 0, 0, 0, 0, 0)};
    vecs[5]  = '{1, 0, 1, 1, 1, 0, 1,  o(0, 1, 3, 0, 0, 0, 0)};
    vecs[6]  = '{1, 0, 1, 1, 1, 0, 5,  o(0, 1, 3, 0, 0, 0, 0)};
    vecs[7]  = '{1, 0, 1, 1, 0, 0, 1,  o(0, 0, 0, 0, 0, 1, 0)};
    vecs[8]  = '{1, 0, 1, 1, 0, 0, 1,  o(0, 0, 0, 0, 0, 0, 0)};
    vecs[9]  = '{1, 0, 1, 1, 0, 0, 18, o(0, 0, 0, 0, 0, 0, 0)};
    vecs[10] = '{1, 0, 1, 1, 0, 0, 1,  o(1, 0, 0, 1, 0, 0, 0)};
    vecs[11] = '{1, 1, 1, 1, 0, 0, 1,  o(1, 0, 0, 0, 0, 0, 0)};
    vecs[12] = '{1, 0, 1, 1, 0, 0, 3,  o(1, 0, 0, 0, 0, 0, 0)};
    vecs[13] = '{1, 0, 1, 1, 0, 0, 1,  o(0, 0, 0, 0, 0, 0, 0)};
    vecs[14] = '{1, 0, 1, 1, 0, 0, 50, o(0, 0, 0, 0, 0, 0, 0)};
    vecs[15] = '{1, 0, 1, 1, 0, 0, 60, o(0, 0, 0, 0, 0, 0, 0)};
    vecs[16] = '{1, 1, 1, 1, 0, 0, 1,  o(1, 0, 0, 0, 0, 0, 0)};
    vecs[17] = '{1, 0, 1, 1, 0, 0, 4,  o(0, 0, 0, 0, 0, 0, 0)};
    vecs[18] = '{1, 0, 1, 1, 1, 0, 1,  o(0, 1, 3, 0, 0, 0, 0)};
    vecs[19] = '{0, 0, 1, 1, 1, 0, 1,  o(0, 0, 4, 0, 0, 0, 0)};

    do_reset();
    foreach (vecs[i]) begin
      en = vecs[i].en; rr = vecs[i].rr; pll = vecs[i].pll; txs = vecs[i].txs;
      lu = vecs[i].lu; ci = vecs[i].ci;
      repeat (vecs[i].n) tick();
      check($sformatf("vec%0d", i), 32'(outs), 32'(vecs[i].exp));
    end

    // No device: retries exhaust into S_FAIL.
    en = 0; rr = 0; pll = 0; txs = 0; lu = 0; ci = 0;
    do_reset();
    en = 1; pll = 1; txs = 1;
    high_cycles = 0; prev_s = 0; cyc = 0;
    while (!link_fail && cyc < 1000) begin
      tick();
      cyc++;
      if (start_comm && !prev_s) rises.push_back(cyc);
      if (start_comm) high_cycles++;
      prev_s = start_comm;
    end
    check("nodev_fail", 32'(link_fail), 32'd1);
    check("nodev_pulses", 32'(rises.size()), 32'd4);
    check("nodev_high", 32'(high_cycles), 32'd16);
    for (int k = 1; k < rises.size(); k++)
      check($sformatf("nodev_gap%0d", k), 32'(rises[k] - rises[k-1]), 32'd124);
    check("nodev_retry", 32'(retry_cnt), 32'd3);
    check("nodev_det", 32'(sstatus_det), 32'd0);

    // Hot-plug from S_FAIL.
    ci = 1;
    tick();
    irqs = int'(cominit_irq);
    check("hp_start", 32'(start_comm), 32'd1);
    check("hp_det1", 32'(sstatus_det), 32'd1);
    ci = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      irqs += int'(cominit_irq);
      check("hp_det_wait", 32'(sstatus_det), 32'd1);
    end
    check("hp_irq_once", 32'(irqs), 32'd1);
    check("hp_start_done", 32'(start_comm), 32'd0);
    lu = 1;
    tick();
    check("hp_det3", 32'(sstatus_det), 32'd3);
    check("hp_rdy", 32'(phy_rdy), 32'd1);

    // Asynchronous reset in the middle of a start_comm pulse.
    rr = 1;
    tick();
    rr = 0;
    tick();
    check("ar_pre", 32'(start_comm), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_outs", 32'(outs), 32'(RST_OUTS));
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Randomized run; comm_init held high through reset must not raise an interrupt.
    lu = 0; ci = 1;
    do_reset();
    for (int k = 0; k < 4000; k++) begin
      en  = ($urandom_range(0, 199) != 0);
      rr  = ($urandom_range(0, 299) == 0);
      pll = ($urandom_range(0, 9) != 0);
      txs = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 149) == 0) lu = ~lu;
      ci  = ($urandom_range(0, 59) == 0);
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sata_phy_ctrl.md
# sata_phy_ctrl

Port-level PHY bring-up controller that sequences the GTX OOB engine. It sits between the port register block (SControl/SStatus) and the OOB engine. It issues StartComm pulses and enforces a link-up timeout with bounded retry and backoff. It also detects link loss and unsolicited COMINIT, and reports SStatus.DET plus PHY-ready status.

## Interface
- C_START_LEN, 16: width of each start_comm pulse, in sys_clk cycles (1..255).
- C_LINK_TIMEOUT, 24'd1_500_000: maximum cycles in S_WAIT_LINK (10 ms at 150 MHz).
- C_BACKOFF, 24'd150_000: idle cycles between failed attempts.
- C_MAX_RETRY, 4'd8: retries after the first attempt before declaring failure.
- sys_clk  in  1  tile0_txusrclk20 domain clock.
- sys_rst_n  in  1  asynchronous, active-low reset.
- port_enable  in  1  level; 0 forces S_DISABLED (SControl.DET=4).
- port_reset_req  in  1  one-cycle pulse; restart bring-up (SControl.DET=1 written).
- plllkdet  in  1  GTX PLL lock.
- tx_sync_done  in  1  GTX TX phase alignment complete.
- link_up  in  1  OOB engine reached ready.
- comm_init  in  1  COMINIT seen (rxstatus[2]), same clock domain.
- start_comm  out  1  restarts the OOB engine; high exactly C_START_LEN cycles per attempt.
- phy_rdy  out  1  high in S_READY.
- sstatus_det  out  4  4'h0 no device, 4'h1 device seen/no comm, 4'h3 established, 4'h4 disabled.
- retry_cnt  out  4  retries consumed in the current bring-up sequence.
- link_fail  out  1  high in S_FAIL.
- link_lost  out  1  one-cycle pulse when link_up falls in S_READY.
- cominit_irq  out  1  one-cycle pulse on a comm_init rising edge while in S_READY or S_FAIL.

## Operation
- States: S_DISABLED, S_WAIT_PLL, S_START, S_WAIT_LINK, S_BACKOFF, S_READY, S_FAIL.
- Priority, highest first: port_enable=0 sends any state to S_DISABLED. Next, port_reset_req sends any other state to S_START with retry_cnt cleared. Normal transitions come last.
- S_DISABLED: when port_enable=1, go to S_WAIT_PLL.
- S_WAIT_PLL: when plllkdet and tx_sync_done are both high, go to S_START with retry_cnt=0.
- S_START: hold C_START_LEN cycles, then go to S_WAIT_LINK.
- S_WAIT_LINK:
  - link_up goes to S_READY.
  - Otherwise, when the timer reaches C_LINK_TIMEOUT-1: go to S_FAIL if retry_cnt==C_MAX_RETRY, else S_BACKOFF.
  - link_up and timeout in the same cycle resolve to S_READY.
- S_BACKOFF: after C_BACKOFF cycles, go to S_START and increment retry_cnt (saturating at 15).
- S_READY: retry_cnt cleared on entry. When link_up falls, pulse link_lost and go to S_BACKOFF.
- S_FAIL: a comm_init rising edge (hot-plug) goes to S_START with retry_cnt=0.
- dev_seen, a sticky flag:
  - Set by comm_init=1.
  - Cleared in S_DISABLED and by port_reset_req.
  - comm_init=1 in the same cycle as port_reset_req wins, so the flag stays set.
- sstatus_det: 4 in S_DISABLED; 3 in S_READY; otherwise 1 if dev_seen, else 0.
- Timer: 24-bit up-counter, cleared on every state change, saturating.
- comm_init edge detection: one registered copy of comm_init. That register resets to 1, so a comm_init already high after reset raises no interrupt.

## Timing
- All outputs are registered and decoded from the next state, so each output changes on the same edge the state enters.
- start_comm rises on the edge entering S_START and falls exactly C_START_LEN edges later.
- A timed-out attempt gives:
  - start_comm high for C_START_LEN cycles;
  - then C_LINK_TIMEOUT cycles in S_WAIT_LINK;
  - then C_BACKOFF cycles in S_BACKOFF;
  - then the next start_comm rising edge.
- link_up sampled high enters S_READY on the following edge; phy_rdy rises on that edge.
- Reset values: state S_DISABLED, start_comm 0, phy_rdy 0, sstatus_det 4'h4, retry_cnt 0, link_fail 0, link_lost 0, cominit_irq 0.
- Asynchronous reset mid-pulse drops start_comm immediately.
- A port_reset_req during S_START restarts the pulse with a full C_START_LEN count.

## Structure
- Package sata_phy_ctrl_pkg holds the state enum and the DET codes (DET_NONE=0, DET_PRESENT=1, DET_PHY=3, DET_OFFLINE=4).
- No sub-module; the timer and edge detector are inline.
- Instantiated alongside gtx_oob; start_comm drives its StartComm input.

## Test plan
Bench parameters: C_START_LEN=4, C_LINK_TIMEOUT=100, C_BACKOFF=20, C_MAX_RETRY=3.
- Happy path: enable, then lock at cycle 10, then link_up 30 cycles after start_comm falls -> exactly one 4-cycle pulse, phy_rdy=1, sstatus_det=3, retry_cnt=0.
- No device: link_up held 0 -> exactly 4 start_comm pulses, 124 cycles between rising edges; link_fail=1; retry_cnt=3; sstatus_det=0.
- Failure then hot-plug: from S_FAIL, pulse comm_init -> cominit_irq pulses once, start_comm pulses, sstatus_det=1 until link_up, then 3.
- Link loss: drop link_up in S_READY -> link_lost single pulse, phy_rdy=0 next edge, new start_comm pulse after 20 cycles.
- Overrides: port_reset_req mid-backoff -> start_comm next edge, retry_cnt=0. port_enable=0 in S_READY -> sstatus_det=4 and start_comm=0 on the next edge.
- Async reset asserted during start_comm -> all outputs at reset values without waiting for a clock edge.
